spi_req_arbiter: RTL and testbench
==================================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, number of idle cycles with all ss_n high between transfers (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, XFER cycles before abort (used only under SPI_ARB_TIMEOUT_EN; legal 2..255).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req  in  4  per-requester transfer request, level, held until matching done.
REQ-006 SHALL have port req_data  in  32  TX byte per requester, byte i at [8i+7:8i].
REQ-007 SHALL have port grant  out  4  one-hot owner of current transfer, zero when none.
REQ-008 SHALL have port done  out  4  one-cycle completion pulse to the owner.
REQ-009 SHALL have port rsp_data  out  8  received byte, valid in the done cycle and held until the next done.
REQ-010 SHALL have port err  out  1  one-cycle timeout pulse, coincident with done.
REQ-011 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have port ss_n  out  4  active-low slave selects, ss_n[i] low only while grant[i] is high and state is LOAD or XFER.
REQ-013 SHALL have port spdr_wdata  out  8  byte written to the SPI data register.
REQ-014 SHALL have port spdr_load  out  1  one-cycle SPDR write strobe.
REQ-015 SHALL have port spif  in  1  SPI transfer-complete flag (level, may span several clk cycles).
REQ-016 SHALL have port spdr_rdata  in  8  SPI received byte, valid while spif is high.

Function
REQ-017 SHALL implement states IDLE, LOAD, XFER, GAP.
REQ-018 IDLE: if any req bit is high, SHALL select the winner round-robin starting at index (last_winner+1) mod 4, set grant, and enter LOAD next cycle; otherwise SHALL stay in IDLE.
REQ-019 last_winner SHALL update only on a grant; first arbitration after reset starts at index 0.
REQ-020 LOAD: SHALL assert spdr_load for exactly one cycle with spdr_wdata = winner's req_data byte, then enter XFER.
REQ-021 spif rising edge SHALL be detected from a registered copy of spif; a spif level already high on XFER entry SHALL NOT complete the transfer.
REQ-022 XFER: on the spif rising edge SHALL capture spdr_rdata into rsp_data, pulse done[winner], and enter GAP in the same cycle.
REQ-023 GAP: SHALL clear grant, drive all ss_n high, hold for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-024 A req deasserted mid-transfer SHALL NOT abort the transfer; done is still pulsed.
REQ-025 New req edges during LOAD/XFER/GAP SHALL be considered only at the next IDLE.
REQ-026 Latency from req high in IDLE to spdr_load SHALL be exactly 2 cycles.

Reset
REQ-027 While rst is low: state=IDLE, grant=0, done=0, err=0, busy=0, ss_n=4'hF, spdr_load=0, spdr_wdata=0, rsp_data=0, last_winner=3, registered spif copy=0.
REQ-028 Reset asserted mid-transfer SHALL immediately release ss_n and abandon the transfer without a done pulse.

Configuration
REQ-029 With SPI_ARB_TIMEOUT_EN defined, SHALL count cycles in XFER; if TIMEOUT_CYCLES elapse without a spif rising edge, SHALL pulse done[winner] and err together, set rsp_data=8'hFF, and enter GAP.
REQ-030 Without SPI_ARB_TIMEOUT_EN, SHALL wait in XFER indefinitely, err SHALL be constant 0, and no timeout counter SHALL be built.

Verification
REQ-031 Single request: req=4'b0100, byte2=8'hA5, spif rises 10 cycles after spdr_load with rdata 8'h3C -> spdr_wdata=8'hA5, ss_n=4'b1011, done=4'b0100, rsp_data=8'h3C.
REQ-032 All four req high continuously -> grant sequence 0,1,2,3,0 with exactly GAP_CYCLES ss_n-high cycles between transfers.
REQ-033 spif held high for 5 cycles and still high at next XFER entry -> second transfer completes only on a fresh spif rising edge.
REQ-034 rst driven low during XFER -> ss_n=4'hF and grant=0 asynchronously; no done pulse; after release, IDLE grants index 0 first.
REQ-035 SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, spif never rises -> done and err pulse after 20 XFER cycles, rsp_data=8'hFF; macro undefined -> busy stays high, err stays 0.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter granting one of four requesters a single-byte SPI transfer.
// Optional XFER timeout abort is built only when SPI_ARB_TIMEOUT_EN is defined.
module spi_req_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [7:0]  rsp_data,
  output logic        err,
  output logic        busy,
  output logic [3:0]  ss_n,
  output logic [7:0]  spdr_wdata,
  output logic        spdr_load,
  input  logic        spif,
  input  logic [7:0]  spdr_rdata
);

  // state | meaning
  // IDLE  | no transfer, arbitrate among pending requests
  // LOAD  | winner selected, slave selected, write SPDR next
  // XFER  | waiting for a fresh spif rising edge
  // GAP   | all selects high for GAP_CYCLES before re-arbitration
  typedef enum logic [1:0] {IDLE, LOAD, XFER, GAP} state_t;

  state_t      state_q;
  logic [3:0]  grant_q, done_q, ss_n_q, gap_q;
  logic [7:0]  rsp_q, wdata_q;
  logic        load_q, busy_q, spif_q;
  logic [1:0]  last_q;

  logic        pick_vld;
  logic [1:0]  pick_idx, cand;
  logic        spif_rise;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    cand     = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign spif_rise = spif & ~spif_q;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [7:0] to_q;
  logic       err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 4'h0;
      done_q  <= 4'h0;
      ss_n_q  <= 4'hF;
      gap_q   <= 4'h0;
      rsp_q   <= 8'h00;
      wdata_q <= 8'h00;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      spif_q  <= 1'b0;
      last_q  <= 2'd3;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q    <= 8'h00;
      err_q   <= 1'b0;
`endif
    end else begin
      spif_q <= spif;
      load_q <= 1'b0;
      done_q <= 4'h0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= 4'b0001 << pick_idx;
            ss_n_q  <= ~(4'b0001 << pick_idx);
            last_q  <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          load_q  <= 1'b1;
          wdata_q <= req_data[{last_q, 3'b000} +: 8];
`ifdef SPI_ARB_TIMEOUT_EN
          to_q    <= 8'(TIMEOUT_CYCLES - 1);
`endif
          state_q <= XFER;
        end
        XFER: begin
          if (spif_rise) begin
            rsp_q   <= spdr_rdata;
            done_q  <= grant_q;
            grant_q <= 4'h0;
            ss_n_q  <= 4'hF;
            gap_q   <= 4'(GAP_CYCLES - 1);
            state_q <= GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_q == 8'd0) begin
            rsp_q   <= 8'hFF;
            done_q  <= grant_q;
            err_q   <= 1'b1;
            grant_q <= 4'h0;
            ss_n_q  <= 4'hF;
            gap_q   <= 4'(GAP_CYCLES - 1);
            state_q <= GAP;
          end else begin
            to_q <= to_q - 8'd1;
          end
`endif
        end
        GAP: begin
          if (gap_q == 4'd0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign grant      = grant_q;
  assign done       = done_q;
  assign rsp_data   = rsp_q;
  assign busy       = busy_q;
  assign ss_n       = ss_n_q;
  assign spdr_wdata = wdata_q;
  assign spdr_load  = load_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_spi_req_arbiter;

  localparam int GAP = 2;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant, done, ss_n;
  logic [7:0]  rsp_data, spdr_wdata, spdr_rdata;
  logic        err, busy, spdr_load, spif;

  int n_chk  = 0;
  int n_fail = 0;

  spi_req_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .rsp_data(rsp_data), .err(err),
    .busy(busy), .ss_n(ss_n), .spdr_wdata(spdr_wdata),
    .spdr_load(spdr_load), .spif(spif), .spdr_rdata(spdr_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] rd;
    logic [7:0]  rdata;
    int          delay;
    logic        drop;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_wdata;
    logic [3:0]  exp_ssn;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_load(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!spdr_load && lat < 40);
    chk("spdr_load_seen", {31'd0, spdr_load}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("return_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_xfer(input vec_t v);
    int lat;
    req = v.req;
    req_data = v.rd;
    wait_load(lat);
    chk("load_latency", lat, 2);
    chk("wdata", {24'd0, spdr_wdata}, {24'd0, v.exp_wdata});
    chk("grant", {28'd0, grant}, {28'd0, v.exp_grant});
    chk("ss_n", {28'd0, ss_n}, {28'd0, v.exp_ssn});
    if (v.drop) req = 4'h0;
    repeat (v.delay) tick();
    spif = 1'b1;
    spdr_rdata = v.rdata;
    tick();
    chk("done", {28'd0, done}, {28'd0, v.exp_grant});
    chk("rsp_data", {24'd0, rsp_data}, {24'd0, v.rdata});
    chk("err_clear", {31'd0, err}, 32'd0);
    chk("gap_ss_n", {28'd0, ss_n}, 32'hF);
    spif = 1'b0;
    spdr_rdata = 8'h00;
    req = 4'h0;
    tick();
    chk("done_one_cycle", {28'd0, done}, 32'd0);
    chk("rsp_held", {24'd0, rsp_data}, {24'd0, v.rdata});
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, bad;
    logic [3:0] exp_g;

    vecs[0] = '{4'b0100, 32'h11A52233, 8'h3C, 10, 1'b0, 4'b0100, 8'hA5, 4'b1011};
    vecs[1] = '{4'b0110, 32'h44556677, 8'h81,  3, 1'b0, 4'b0010, 8'h66, 4'b1101};
    vecs[2] = '{4'b1111, 32'hDEADBEEF, 8'h00,  1, 1'b0, 4'b0100, 8'hAD, 4'b1011};
    vecs[3] = '{4'b1001, 32'hDEADBEEF, 8'hFF,  5, 1'b0, 4'b1000, 8'hDE, 4'b0111};
    vecs[4] = '{4'b0001, 32'hCAFE0012, 8'h7E,  2, 1'b1, 4'b0001, 8'h12, 4'b1110};
    vecs[5] = '{4'b1100, 32'h9876ABCD, 8'hC3,  0, 1'b0, 4'b0100, 8'h76, 4'b1011};

    rst = 1'b0;
    req = 4'hF;
    req_data = 32'hFFFFFFFF;
    spif = 1'b0;
    spdr_rdata = 8'h00;
    tick();
    tick();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ss_n", {28'd0, ss_n}, 32'hF);
    chk("rst_load", {31'd0, spdr_load}, 32'd0);
    chk("rst_wdata", {24'd0, spdr_wdata}, 32'd0);
    chk("rst_rsp", {24'd0, rsp_data}, 32'd0);
    req = 4'h0;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

    // spif still high from previous transfer must not complete the next one
    req = 4'b0001;
    req_data = 32'h00000077;
    wait_load(lat);
    spif = 1'b1;
    spdr_rdata = 8'h11;
    tick();
    chk("hold_first_done", {28'd0, done}, 32'b0001);
    req = 4'b0010;
    bad = 0;
    lat = 0;
    do begin
      tick();
      lat++;
      if (done != 4'h0) bad++;
    end while (!spdr_load && lat < 40);
    chk("hold_second_load", {31'd0, spdr_load}, 32'd1);
    repeat (3) begin
      tick();
      if (done != 4'h0) bad++;
    end
    chk("hold_no_stale_done", bad, 0);
    spif = 1'b0;
    tick();
    spif = 1'b1;
    spdr_rdata = 8'h5A;
    tick();
    chk("hold_second_done", {28'd0, done}, 32'b0010);
    chk("hold_second_rsp", {24'd0, rsp_data}, 32'h5A);
    spif = 1'b0;
    req = 4'h0;
    wait_idle();

    // asynchronous reset in the middle of a transfer
    req = 4'b0100;
    wait_load(lat);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_ss_n", {28'd0, ss_n}, 32'hF);
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("arst_no_done", {28'd0, done}, 32'd0);
    req = 4'hF;
    rst = 1'b1;

    // all requesters held: round robin from index 0 with GAP-cycle separation
    req_data = 32'h44332211;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << (t % 4);
      wait_load(lat);
      chk("rr_grant", {28'd0, grant}, {28'd0, exp_g});
      tick();
      tick();
      spif = 1'b1;
      spdr_rdata = 8'(8'h10 + t);
      tick();
      chk("rr_done", {28'd0, done}, {28'd0, exp_g});
      spif = 1'b0;
      if (t < 4) begin
        cnt = 0;
        while (busy && cnt < 50) begin
          if (ss_n == 4'hF) cnt++;
          tick();
        end
        chk("rr_gap_cycles", cnt, GAP);
      end
    end
    req = 4'h0;
    wait_idle();

    req = 4'b1000;
    wait_load(lat);
`ifdef SPI_ARB_TIMEOUT_EN
    cnt = 0;
    while (done == 4'h0 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("to_cycles", cnt, TO);
    chk("to_done", {28'd0, done}, 32'b1000);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rsp", {24'd0, rsp_data}, 32'hFF);
    req = 4'h0;
    tick();
    chk("to_err_pulse", {31'd0, err}, 32'd0);
    wait_idle();
`else
    bad = 0;
    repeat (40) begin
      tick();
      if (busy !== 1'b1 || err !== 1'b0 || done !== 4'h0) bad++;
    end
    chk("no_timeout_wait", bad, 0);
    spif = 1'b1;
    spdr_rdata = 8'h99;
    tick();
    chk("late_done", {28'd0, done}, 32'b1000);
    chk("late_rsp", {24'd0, rsp_data}, 32'h99);
    spif = 1'b0;
    req = 4'h0;
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
